// File: rtl/nn_image_pkg.sv
// -----------------------------------------------------------------------------
// nn_image_pkg
// Constants shared by the image memory write side (image_memory_writer), the
// NN read side and the VGA grid renderer.
//   IMG_W / IMG_PIXELS : square drawing grid geometry
//   PIXEL_ON_WORD      : Q16.16 value stored for an inked pixel
//   ST_*               : writer FSM state encoding
//   coord_t            : 6-bit (x,y) pair; one spare bit so that a neighbour
//                        stepping off the grid stays detectably out of range
//   brush_coord()      : plus-shaped brush slot -> pixel coordinate
// -----------------------------------------------------------------------------
package nn_image_pkg;

    localparam int          IMG_W         = 28;
    localparam int          IMG_PIXELS    = IMG_W * IMG_W;   // 784
    localparam logic [31:0] PIXEL_ON_WORD = 32'h0001_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PAINT = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam int          BRUSH_SLOTS = 5;
    localparam logic [2:0]  BRUSH_LAST  = 3'(BRUSH_SLOTS - 1);

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
    } coord_t;

    // Slot order: centre, left, right, up, down. Stepping left from column 0
    // wraps to 63 and stepping right from 31 gives 32, both outside the grid,
    // so the range check downstream catches every off-grid neighbour.
    function automatic coord_t brush_coord(input logic [4:0] x,
                                           input logic [4:0] y,
                                           input logic [2:0] slot);
        coord_t c;
        c.x = {1'b0, x};
        c.y = {1'b0, y};
        case (slot)
            3'd1:    c.x = c.x - 6'd1;
            3'd2:    c.x = c.x + 6'd1;
            3'd3:    c.y = c.y - 6'd1;
            3'd4:    c.y = c.y + 6'd1;
            default: c   = c;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/image_addr_calc.sv
// -----------------------------------------------------------------------------
// image_addr_calc
// Combinational (x,y) -> linear image address, shared with the VGA renderer.
//   x_i, y_i    : 6-bit coordinates (bit 5 set means off-grid)
//   addr_o      : y*28 + x, 10 bits, exact for all 5-bit inputs (max 899)
//   in_range_o  : both coordinates inside 0..IMG_W-1
// -----------------------------------------------------------------------------
module image_addr_calc #(
    parameter int IMG_W = 28
) (
    input  logic [5:0] x_i,
    input  logic [5:0] y_i,
    output logic [9:0] addr_o,
    output logic       in_range_o
);

    logic [9:0] x_ext;
    logic [9:0] y_ext;

    assign x_ext = {5'b0, x_i[4:0]};
    assign y_ext = {5'b0, y_i[4:0]};

    // 28 = 16 + 8 + 4, so the multiply collapses to three shifted adds.
    assign addr_o = (y_ext << 4) + (y_ext << 3) + (y_ext << 2) + x_ext;

    assign in_range_o = (x_i < 6'(IMG_W)) && (y_i < 6'(IMG_W));

endmodule

// File: rtl/image_memory_writer.sv
// -----------------------------------------------------------------------------
// image_memory_writer
// Write-side controller of the 28x28 image memory read by the NN.
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : brush command handshake (cmd_x, cmd_y, cmd_erase)
//   clear_req           : pulse requesting a full-image clear
//   wr_en/wr_addr/wr_data : registered memory write port
//   busy                : PAINT or CLEAR in progress
//   image_ready         : idle with no pending clear; NN may start
//   cmd_err             : one-cycle pulse after accepting an off-grid command
// A command paints a plus-shaped brush in exactly five cycles; off-grid slots
// keep their cycle with wr_en low so brush timing never varies. A clear sweeps
// all pixels with zero, one per cycle. Clear requests arriving while busy are
// collapsed into one pending flag served right after the current operation.
// -----------------------------------------------------------------------------
module image_memory_writer
    import nn_image_pkg::*;
#(
    parameter int                IMG_W          = nn_image_pkg::IMG_W,
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] PIXEL_ON       = nn_image_pkg::PIXEL_ON_WORD,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_x,
    input  logic [4:0]        cmd_y,
    input  logic              cmd_erase,
    input  logic              clear_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              image_ready,
    output logic              cmd_err
);

    // Value of the clear counter once the last pixel has been issued.
    localparam logic [9:0] CLR_END     = 10'(IMG_W * IMG_W);
    localparam logic [1:0] RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [1:0]        state_q,   state_d;
    logic [2:0]        slot_q,    slot_d;
    logic [4:0]        x_q,       x_d;
    logic [4:0]        y_q,       y_d;
    logic              erase_q,   erase_d;
    logic              bad_q,     bad_d;
    logic              pending_q, pending_d;
    logic [9:0]        clr_cnt_q, clr_cnt_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              cmd_err_q, cmd_err_d;

    logic              launch_clear;
    logic              clear_wanted;
    logic [DATA_W-1:0] brush_data;
    coord_t            calc_in;
    logic [9:0]        calc_addr;
    logic              calc_in_range;

    // ---------------------------------------------------------------------
    // One address calculator serves both the handshake cycle (centre taken
    // straight from the command inputs) and the remaining brush slots
    // (neighbour of the latched centre for the slot about to be issued).
    // ---------------------------------------------------------------------
    always_comb begin
        calc_in = '0;
        if (state_q == ST_IDLE) begin
            calc_in.x = {1'b0, cmd_x};
            calc_in.y = {1'b0, cmd_y};
        end else begin
            calc_in = brush_coord(x_q, y_q, slot_q + 3'd1);
        end
    end

    image_addr_calc #(
        .IMG_W (IMG_W)
    ) u_addr_calc (
        .x_i        (calc_in.x),
        .y_i        (calc_in.y),
        .addr_o     (calc_addr),
        .in_range_o (calc_in_range)
    );

    // Status outputs are decoded from state so they agree with it exactly.
    // A clear request in IDLE takes priority, so the command is refused.
    assign cmd_ready   = (state_q == ST_IDLE) && !clear_req && !pending_q;
    assign busy        = (state_q != ST_IDLE);
    assign image_ready = (state_q == ST_IDLE) && !pending_q;

    assign clear_wanted = clear_req || pending_q;
    assign brush_data   = erase_q ? '0 : PIXEL_ON;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        x_d          = x_q;
        y_d          = y_q;
        erase_d      = erase_q;
        bad_d        = bad_q;
        pending_d    = pending_q;
        clr_cnt_d    = clr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cmd_err_d    = 1'b0;
        launch_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_wanted) begin
                    launch_clear = 1'b1;
                end else if (cmd_valid) begin
                    // Centre slot is issued on the handshake edge itself.
                    state_d   = ST_PAINT;
                    slot_d    = 3'd0;
                    x_d       = cmd_x;
                    y_d       = cmd_y;
                    erase_d   = cmd_erase;
                    bad_d     = !calc_in_range;
                    cmd_err_d = !calc_in_range;
                    wr_en_d   = calc_in_range;
                    wr_addr_d = {{(ADDR_W-10){1'b0}}, calc_addr};
                    wr_data_d = cmd_erase ? '0 : PIXEL_ON;
                end
            end

            ST_PAINT: begin
                pending_d = clear_wanted;
                if (slot_q == BRUSH_LAST) begin
                    if (clear_wanted) begin
                        launch_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // An off-grid command suppresses every slot, including
                    // neighbours that happen to fall back onto the grid.
                    slot_d    = slot_q + 3'd1;
                    wr_en_d   = calc_in_range && !bad_q;
                    wr_addr_d = {{(ADDR_W-10){1'b0}}, calc_addr};
                    wr_data_d = brush_data;
                end
            end

            ST_CLEAR: begin
                pending_d = clear_wanted;
                if (clr_cnt_q == CLR_END) begin
                    // A request seen during the sweep restarts it once.
                    if (clear_wanted) begin
                        launch_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {{(ADDR_W-10){1'b0}}, clr_cnt_q};
                    wr_data_d = '0;
                    clr_cnt_d = clr_cnt_q + 10'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starting a clear issues address 0 on the same edge, so a clear
        // that follows a brush begins on the very next cycle.
        if (launch_clear) begin
            state_d   = ST_CLEAR;
            pending_d = 1'b0;
            clr_cnt_d = 10'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            slot_q    <= 3'd0;
            x_q       <= 5'd0;
            y_q       <= 5'd0;
            erase_q   <= 1'b0;
            bad_q     <= 1'b0;
            pending_q <= 1'b0;
            clr_cnt_q <= 10'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            erase_q   <= erase_d;
            bad_q     <= bad_d;
            pending_q <= pending_d;
            clr_cnt_q <= clr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_image_memory_writer.sv
// -----------------------------------------------------------------------------
// tb_image_memory_writer
// Operations are modelled as a queue of expected per-cycle output records:
// each accepted command or clear appends its cycles, and a single compare
// process pops one record per cycle. Writes seen are logged so that directed
// tests can also be pinned against hand-computed address lists.
// -----------------------------------------------------------------------------
module tb_image_memory_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic        cmd_erase;
    logic        clear_req;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        image_ready;
    logic        cmd_err;

    image_memory_writer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_erase   (cmd_erase),
        .clear_req   (clear_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .image_ready (image_ready),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        int          addr;
        logic [31:0] data;
        bit          err;
        bit          busy;
    } rec_t;

    rec_t        exp_q[$];
    int          cap_q[$];
    logic [31:0] capd_q[$];
    int          err_seen = 0;
    int          checks   = 0;
    int          errors   = 0;
    bit          run_cmp  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic void push_noop_busy();
        rec_t r;
        r.en = 1'b0; r.addr = 0; r.data = 32'h0; r.err = 1'b0; r.busy = 1'b1;
        exp_q.push_back(r);
    endfunction

    function automatic void push_paint(input int x, input int y, input bit erase);
        int dx[5] = '{0, -1, 1, 0, 0};
        int dy[5] = '{0, 0, 0, -1, 1};
        bit bad = (x > 27) || (y > 27);
        for (int k = 0; k < 5; k++) begin
            rec_t r;
            int nx = x + dx[k];
            int ny = y + dy[k];
            r.en   = !bad && nx >= 0 && nx < 28 && ny >= 0 && ny < 28;
            r.addr = ny * 28 + nx;
            r.data = erase ? 32'h0 : 32'h0001_0000;
            r.err  = bad && (k == 0);
            r.busy = 1'b1;
            exp_q.push_back(r);
        end
    endfunction

    function automatic void push_clear();
        for (int a = 0; a < 784; a++) begin
            rec_t r;
            r.en = 1'b1; r.addr = a; r.data = 32'h0; r.err = 1'b0; r.busy = 1'b1;
            exp_q.push_back(r);
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        rec_t r;
        if (!reset && run_cmp) begin
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
            end else begin
                r.en = 1'b0; r.addr = 0; r.data = 32'h0; r.err = 1'b0; r.busy = 1'b0;
            end
            chk("wr_en", {31'b0, wr_en}, {31'b0, r.en});
            if (r.en) begin
                chk("wr_addr", {16'b0, wr_addr}, r.addr);
                chk("wr_data", wr_data, r.data);
            end
            chk("cmd_err", {31'b0, cmd_err}, {31'b0, r.err});
            chk("busy", {31'b0, busy}, {31'b0, r.busy});
            chk("image_ready", {31'b0, image_ready}, {31'b0, !r.busy});
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, (!r.busy && !clear_req)});
            if (wr_en) begin
                cap_q.push_back(int'(wr_addr));
                capd_q.push_back(wr_data);
            end
            if (cmd_err) err_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: %0d records left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_cmd(input int x, input int y, input bit erase, input int clr_at);
        @(negedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_x     = 5'(x);
        cmd_y     = 5'(y);
        cmd_erase = erase;
        @(posedge clk);
        push_paint(x, y, erase);
        #1;
        cmd_valid = 1'b0;
        if (clr_at >= 1) begin
            repeat (clr_at - 1) @(posedge clk);
            #1;
            clear_req = 1'b1;
            @(posedge clk);
            push_clear();
            #1;
            clear_req = 1'b0;
        end
    endtask

    task automatic request_clear();
        @(negedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk);
        push_clear();
        #1;
        clear_req = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        run_cmp = 1'b1;
        push_noop_busy();
        @(posedge clk);
        push_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lit5[5];
        int lit3[3];
        int e0;
        int n;

        reset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0;
        cmd_erase = 1'b0; clear_req = 1'b0;

        // Reset values
        #3;
        chk("rst_wr_en",       {31'b0, wr_en}, 0);
        chk("rst_wr_addr",     {16'b0, wr_addr}, 0);
        chk("rst_wr_data",     wr_data, 0);
        chk("rst_cmd_err",     {31'b0, cmd_err}, 0);
        chk("rst_busy",        {31'b0, busy}, 1);
        chk("rst_image_ready", {31'b0, image_ready}, 0);
        chk("rst_cmd_ready",   {31'b0, cmd_ready}, 0);

        // Automatic clear after reset release
        release_reset();
        wait_idle();
        @(negedge clk); #1;
        chk("post_clear_image_ready", {31'b0, image_ready}, 1);
        chk("post_clear_cmd_ready",   {31'b0, cmd_ready}, 1);
        chk("post_clear_count", cap_q.size(), 784);
        chk("post_clear_first", cap_q[0], 0);
        chk("post_clear_last",  cap_q[783], 783);
        $display("txn reset-clear: %0d writes", cap_q.size());

        // Paint (5,5)
        cap_q.delete(); capd_q.delete();
        send_cmd(5, 5, 1'b0, 0);
        wait_idle();
        lit5 = '{145, 144, 146, 117, 173};
        chk("paint55_count", cap_q.size(), 5);
        for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
            chk("paint55_addr", cap_q[i], lit5[i]);
            chk("paint55_data", capd_q[i], 32'h0001_0000);
        end
        $display("txn paint(5,5): %0d writes", cap_q.size());

        // Paint (0,0): left and up neighbours fall off the grid
        cap_q.delete(); capd_q.delete();
        send_cmd(0, 0, 1'b0, 0);
        wait_idle();
        lit3 = '{0, 1, 28};
        chk("paint00_count", cap_q.size(), 3);
        for (int i = 0; i < 3 && i < cap_q.size(); i++)
            chk("paint00_addr", cap_q[i], lit3[i]);
        $display("txn paint(0,0): %0d writes", cap_q.size());

        // Out-of-range command (30,3)
        cap_q.delete(); capd_q.delete();
        e0 = err_seen;
        send_cmd(30, 3, 1'b0, 0);
        wait_idle();
        chk("bad_cmd_writes", cap_q.size(), 0);
        chk("bad_cmd_err_pulses", err_seen - e0, 1);
        $display("txn cmd(30,3): err pulses %0d", err_seen - e0);

        // Paint (12,20) erase, model-checked
        cap_q.delete(); capd_q.delete();
        send_cmd(12, 20, 1'b1, 0);
        wait_idle();
        chk("erase1220_count", cap_q.size(), 5);
        $display("txn erase(12,20): %0d writes", cap_q.size());

        // Erase (27,27) with clear_req on the 2nd PAINT cycle
        cap_q.delete(); capd_q.delete();
        send_cmd(27, 27, 1'b1, 2);
        wait_idle();
        lit3 = '{783, 782, 755};
        chk("erase2727_count", cap_q.size(), 3 + 784);
        for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
            chk("erase2727_addr", cap_q[i], lit3[i]);
            chk("erase2727_data", capd_q[i], 0);
        end
        if (cap_q.size() > 3) chk("pending_clear_first", cap_q[3], 0);
        $display("txn erase(27,27)+clear: %0d writes", cap_q.size());

        // clear_req and cmd_valid together: clear wins, no handshake
        cap_q.delete(); capd_q.delete();
        @(negedge clk); #1;
        clear_req = 1'b1; cmd_valid = 1'b1; cmd_x = 5'd3; cmd_y = 5'd3; cmd_erase = 1'b0;
        #1;
        chk("collide_cmd_ready", {31'b0, cmd_ready}, 0);
        @(posedge clk);
        push_clear();
        #1;
        clear_req = 1'b0; cmd_valid = 1'b0;
        wait_idle();
        chk("collide_count", cap_q.size(), 784);
        $display("txn clear+cmd collide: %0d writes", cap_q.size());

        // Reset asserted at clear address 400
        cap_q.delete(); capd_q.delete();
        request_clear();
        n = 0;
        while (cap_q.size() < 401 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("midclear_reached", cap_q.size(), 401);
        if (cap_q.size() > 0) chk("midclear_last", cap_q[cap_q.size()-1], 400);
        reset = 1'b1;
        #1;
        chk("async_wr_en",   {31'b0, wr_en}, 0);
        chk("async_wr_addr", {16'b0, wr_addr}, 0);
        chk("async_busy",    {31'b0, busy}, 1);
        exp_q.delete(); cap_q.delete(); capd_q.delete();
        @(posedge clk);
        release_reset();
        wait_idle();
        chk("reclear_count", cap_q.size(), 784);
        if (cap_q.size() > 0) chk("reclear_first", cap_q[0], 0);
        $display("txn reset mid-clear: restart %0d writes", cap_q.size());

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_memory_writer.md
Name: image_memory_writer

Overview:
- Write-side controller for the 28x28 image memory.
- The neural network consumes this memory through its read port (image_read_addr / image_data_out); this block produces all writes into it.
- Accepts paint/erase brush commands from the drawing-grid cursor logic and performs full-image clears.
- Exposes image_ready so the NN start logic only runs on a stable image.

Parameters:
- IMG_W, 28, image width/height in pixels (square image)
- ADDR_W, 16, memory address width (matches NN image_read_addr)
- DATA_W, 32, memory word width (matches image_data_out)
- PIXEL_ON, 32'h0001_0000, word written for an inked pixel (Q16.16 1.0)
- CLEAR_ON_RESET, 1, if 1, a full clear runs automatically after reset release

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  brush command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_x  in  5  cursor column, 0..27 valid
- cmd_y  in  5  cursor row, 0..27 valid
- cmd_erase  in  1  0 = paint PIXEL_ON, 1 = write 0
- clear_req  in  1  single-cycle pulse requesting a full clear
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  write address = y*IMG_W + x
- wr_data  out  DATA_W  write data
- busy  out  1  PAINT or CLEAR in progress
- image_ready  out  1  high in IDLE with no pending clear
- cmd_err  out  1  one-cycle pulse when an out-of-range command is accepted

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, cmd_err=0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - cmd_ready, busy and image_ready follow the state (CLEAR: 0/1/0; IDLE: 1/0/1).
- States: IDLE, PAINT, CLEAR.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches x, y and erase, then goes to PAINT.
  - A clear_req, or a pending clear flag, goes to CLEAR.
  - If clear_req and cmd_valid arrive in the same cycle, CLEAR wins and cmd_ready is driven 0 that cycle (no handshake).
- PAINT:
  - Exactly 5 cycles, a plus-shaped brush. Slot order: centre, (x-1,y), (x+1,y), (x,y-1), (x,y+1).
  - Slot k drives wr_addr/wr_data/wr_en on cycle k+1 after the handshake; registered outputs.
  - wr_data = erase ? 0 : PIXEL_ON.
  - A neighbour outside 0..27 keeps its slot with wr_en=0, so timing is fixed.
  - After slot 5, return to IDLE.
- Out-of-range command (x>27 or y>27):
  - Still accepted.
  - cmd_err pulses on the cycle after the handshake.
  - PAINT runs all 5 slots with wr_en=0.
- CLEAR:
  - Writes 0 to addresses 0..783, one per cycle, with wr_en=1.
  - 784 cycles, then IDLE.
  - The address counter is 10 bits, zero-extended to ADDR_W; it never wraps past 783.
- clear_req during PAINT or CLEAR sets the pending flag.
  - The flag is served right after the current operation.
  - Multiple requests collapse into one.
  - A request during CLEAR does restart the sweep once.
- busy = (state != IDLE). image_ready = IDLE & ~pending.
- Address arithmetic: y*28 + x computed as (y<<4)+(y<<3)+(y<<2)+x, 10-bit, no truncation for in-range inputs.
- Reset asserted mid-operation: everything returns to reset values immediately; a partial brush or clear is abandoned, not completed.
- wr_en is never high in IDLE.

Decomposition:
- Shared package (nn_image_pkg): IMG_W, IMG_PIXELS=784, PIXEL_ON, state encoding. The NN read side uses the same constants.
- One sub-module: image_addr_calc, the combinational (x,y) -> address with an in-range flag, shared with the VGA grid renderer.

Test Plan:
- Reset release, CLEAR_ON_RESET=1:
  - 784 consecutive writes of 0, addresses 0..783.
  - Then image_ready=1 and cmd_ready=1.
- Paint (x=5, y=5) with erase=0:
  - 5 writes of 32'h00010000, in order, to addresses 145, 144, 146, 117, 173.
  - Writes occupy cycles 1..5 after the handshake.
- Paint (0, 0):
  - Only slots 1, 3, 5 write (addresses 0, 1, 28).
  - Slots 2 and 4 have wr_en=0; total still 5 cycles.
- Command (x=30, y=3):
  - cmd_err pulses 1 cycle after the handshake.
  - No writes; back in IDLE 5 cycles later.
- clear_req on the 2nd PAINT cycle of an erase at (27, 27):
  - Brush completes (writes 783, 782, 755).
  - CLEAR starts the next cycle; image_ready stays 0 throughout.
- Reset asserted at clear address 400:
  - wr_en drops asynchronously.
  - After release, a new clear starts again at address 0.
